// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), 1 stop. Mid-bit sampling on a
// synchronised pin, with valid/framing-error/overrun flags cleared by an ack pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pin,
  input  logic [7:0] ctrl,
  output logic [7:0] data,
  output logic       state_rx_valid,
  output logic       state_rx_busy,
  output logic       state_rx_ferr,
  output logic       state_rx_ovr
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((H > 0) ? H - 1 : 0);

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic [2:0]             bitcnt;
  logic [7:0]             shift;
  logic                   rx_en, ack, tick;
  logic                   sample_bit, done_ok, done_err;

  assign rx_en = ctrl[0];
  assign ack   = ctrl[1];
  assign sync  = sync_q[SYNC_STAGES-1];
  assign tick  = (state == START) ? (cnt == CNT_HALF) : (cnt == CNT_BIT);

  // Synchroniser resets to the idle line level so reset never fakes a start bit.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // State register; busy is registered alongside so it tracks state exactly.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state         <= IDLE;
      state_rx_busy <= 1'b0;
    end else begin
      state         <= state_n;
      state_rx_busy <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (rx_en && !sync) state_n = (H == 0) ? DATA : START;
      START: if (tick) state_n = sync ? IDLE : DATA;
      DATA:  if (tick && bitcnt == 3'd7) state_n = STOP;
      STOP:  if (tick) state_n = sync ? IDLE : BREAK;
      BREAK: if (sync) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!rx_en) state_n = IDLE;
  end

  // Event strobes; a disabled receiver never commits anything.
  always_comb begin
    sample_bit = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    if (rx_en && tick) begin
      sample_bit = (state == DATA);
      done_ok    = (state == STOP) && sync;
      done_err   = (state == STOP) && !sync;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt    <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      if (state_n != state || tick || state == IDLE || state == BREAK) cnt <= '0;
      else                                                             cnt <= cnt + 1'b1;
      if (state != DATA) bitcnt <= '0;
      else if (tick)     bitcnt <= bitcnt + 3'd1;
      if (sample_bit) shift[bitcnt] <= sync;
    end
  end

  // Completion is applied after the ack clear, so a same-cycle completion wins.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      data           <= '0;
      state_rx_valid <= 1'b0;
      state_rx_ferr  <= 1'b0;
      state_rx_ovr   <= 1'b0;
    end else begin
      if (ack) begin
        state_rx_valid <= 1'b0;
        state_rx_ferr  <= 1'b0;
        state_rx_ovr   <= 1'b0;
      end
      if (done_ok) begin
        data           <= shift;
        state_rx_valid <= 1'b1;
        if (state_rx_valid && !ack) state_rx_ovr <= 1'b1;
      end
      if (done_err) begin
        data          <= shift;
        state_rx_ferr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clk/bit, one at 8 clk/bit,
// sharing clock and reset. Inputs change and outputs are sampled on negedge.
module tb_uart_rx;

  logic       clk, rst;
  logic       pin1, pin8;
  logic [7:0] ctrl1, ctrl8;
  logic [7:0] data1, data8;
  logic       valid1, busy1, ferr1, ovr1;
  logic       valid8, busy8, ferr8, ovr8;
  int         n_tests = 0;
  int         n_fail  = 0;

  uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .resetn(rst), .pin(pin1), .ctrl(ctrl1), .data(data1),
    .state_rx_valid(valid1), .state_rx_busy(busy1),
    .state_rx_ferr(ferr1), .state_rx_ovr(ovr1));

  uart_rx #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .resetn(rst), .pin(pin8), .ctrl(ctrl8), .data(data8),
    .state_rx_valid(valid8), .state_rx_busy(busy8),
    .state_rx_ferr(ferr8), .state_rx_ovr(ovr8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit set at the first negedge (n0); stop bit set at n0+9; line left as-is.
  task automatic send1(input logic [7:0] b, input logic stop);
    @(negedge clk) pin1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) pin1 = b[i];
    end
    @(negedge clk) pin1 = stop;
  endtask

  // Each bit held for 8 negedges; returns at n0+79.
  task automatic send8(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) pin8 = fr[i];
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic ack1();
    @(negedge clk) ctrl1 = 8'h03;
    @(negedge clk) ctrl1 = 8'h01;
  endtask

  task automatic ack8();
    @(negedge clk) ctrl8 = 8'h03;
    @(negedge clk) ctrl8 = 8'h01;
  endtask

  initial begin
    rst = 1'b1; pin1 = 1'b1; pin8 = 1'b1; ctrl1 = 8'h01; ctrl8 = 8'h01;
    repeat (3) @(negedge clk);
    chk("rst_data1", data1, 8'h00);
    chk("rst_flags1", {4'h0, valid1, busy1, ferr1, ovr1}, 8'h00);
    chk("rst_flags8", {4'h0, valid8, busy8, ferr8, ovr8}, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: 0xA5, valid rises exactly at tp+S+10
    send1(8'hA5, 1'b1);
    @(negedge clk) pin1 = 1'b1;
    @(negedge clk) chk("t1_valid_early", {7'h0, valid1}, 8'h00);
    @(negedge clk);
    chk("t1_valid", {7'h0, valid1}, 8'h01);
    chk("t1_data", data1, 8'hA5);
    chk("t1_ferr_ovr", {6'h0, ferr1, ovr1}, 8'h00);

    // 2: back-to-back frames without ack -> overrun
    ack1();
    chk("t2_ack_clear", {7'h0, valid1}, 8'h00);
    send1(8'h3C, 1'b1);
    send1(8'hC3, 1'b1);
    @(negedge clk) pin1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_data", data1, 8'hC3);
    chk("t2_valid_ovr", {6'h0, valid1, ovr1}, 8'h03);
    ack1();
    chk("t2_after_ack", {6'h0, valid1, ovr1}, 8'h00);

    // receiver disabled: low line is ignored
    ctrl1 = 8'h00;
    send1(8'h77, 1'b1);
    @(negedge clk) pin1 = 1'b1;
    repeat (4) @(negedge clk);
    chk("dis_valid_busy", {6'h0, valid1, busy1}, 8'h00);
    chk("dis_data", data1, 8'hC3);
    ctrl1 = 8'h01;
    repeat (3) @(negedge clk);

    // ack in the same cycle as frame completion: completion wins
    send1(8'h11, 1'b1);
    @(negedge clk) pin1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("same_pre_valid", {7'h0, valid1}, 8'h01);
    send1(8'h22, 1'b1);
    @(negedge clk) pin1 = 1'b1;
    @(negedge clk) ctrl1 = 8'h03;
    @(negedge clk) ctrl1 = 8'h01;
    chk("same_data", data1, 8'h22);
    chk("same_valid_ovr", {6'h0, valid1, ovr1}, 8'h02);
    ack1();

    // 3: framing error, line held low, then released
    send1(8'h55, 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_flags", {4'h0, valid1, busy1, ferr1, ovr1}, 8'h06);
    chk("t3_data", data1, 8'h55);
    repeat (2) @(negedge clk);
    chk("t3_busy_low", {7'h0, busy1}, 8'h01);
    @(negedge clk) pin1 = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_busy_rel", {7'h0, busy1}, 8'h00);
    repeat (15) @(negedge clk);
    chk("t3_no_frame", {4'h0, valid1, busy1, ferr1, ovr1}, 8'h02);
    ack1();
    chk("t3_ack", {7'h0, ferr1}, 8'h00);

    // 8 clk/bit good frame
    send8(8'h5A, 1'b1);
    @(negedge clk) pin8 = 1'b1;
    @(negedge clk);
    chk("c8_data", data8, 8'h5A);
    chk("c8_flags", {4'h0, valid8, busy8, ferr8, ovr8}, 8'h08);
    ack8();

    // 4: one-cycle glitch rejected at the mid-start check
    @(negedge clk) pin8 = 1'b0;
    @(negedge clk) pin8 = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_busy_start", {7'h0, busy8}, 8'h01);
    repeat (3) @(negedge clk);
    chk("t4_idle", {4'h0, valid8, busy8, ferr8, ovr8}, 8'h00);
    chk("t4_data", data8, 8'h5A);

    // 5: 0x81, rx_en dropped after bit 3 sampled
    @(negedge clk) pin8 = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) pin8 = (i == 0);
      repeat (7) @(negedge clk);
    end
    @(negedge clk);
    chk("t5_busy_pre", {7'h0, busy8}, 8'h01);
    ctrl8 = 8'h00;
    @(negedge clk);
    chk("t5_abort", {6'h0, valid8, busy8}, 8'h00);
    chk("t5_data", data8, 8'h5A);
    pin8 = 1'b1;
    repeat (4) @(negedge clk);
    ctrl8 = 8'h01;
    repeat (4) @(negedge clk);

    // 6: reset mid-frame of 0xFF, then 0x12
    @(negedge clk) pin8 = 1'b0;
    repeat (8) @(negedge clk);
    pin8 = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_busy_data", {7'h0, busy8}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst8", {data8[3:0], valid8, busy8, ferr8, ovr8}, 8'h00);
    chk("t6_rst_data8", data8, 8'h00);
    chk("t6_rst_data1", data1, 8'h00);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send8(8'h12, 1'b1);
    @(negedge clk) pin8 = 1'b1;
    @(negedge clk);
    chk("t6_data", data8, 8'h12);
    chk("t6_flags", {4'h0, valid8, busy8, ferr8, ovr8}, 8'h08);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
